// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flagged synchronous FIFO.
// Pointer width (one wrap bit above the index bits) and read-mode encodings.
package sync_fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array for the FIFO.
// The write port is synchronous and the read port is asynchronous.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0]    w_data,
   input  logic [$clog2(DEPTH)-1:0] r_addr,
   output logic [DATA_WIDTH-1:0]    r_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable registered or FWFT read.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      w_en,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      r_en,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [ptr_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      err_clr
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] AF_TH = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_TH = PW'(AE_LEVEL);
   localparam logic [PW-1:0] ONE   = PW'(1);

   if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 4");
   end
   if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_LEVEL must not exceed DEPTH");
   end
   if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_flags: AE_LEVEL must be below DEPTH");
   end
   if ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON)) begin : g_bad_fwft
      $error("sync_fifo_flags: FWFT must be 0 or 1");
   end

   logic [PW-1:0]         w_ptr;
   logic [PW-1:0]         r_ptr;
   logic [PW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  overflow_q;
   logic                  underflow_q;

   // Equal index bits with differing wrap bits means the writer lapped the reader.
   assign empty = (w_ptr == r_ptr);
   assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);

   // A full FIFO still takes a write when the head is popped in the same cycle.
   assign rd_ok = r_en && !empty;
   assign wr_ok = w_en && (!full || rd_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr       <= '0;
         r_ptr       <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            w_ptr <= w_ptr + ONE;
         end
         if (rd_ok) begin
            r_ptr <= r_ptr + ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + ONE;
            2'b01:   count_q <= count_q - ONE;
            default: count_q <= count_q;
         endcase
         // A new error in the clearing cycle survives the clear.
         overflow_q  <= (w_en && !wr_ok) || (overflow_q && !err_clr);
         underflow_q <= (r_en && !rd_ok) || (underflow_q && !err_clr);
      end
   end

   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign almost_full  = (count_q >= AF_TH);
   assign almost_empty = (count_q <= AE_TH);

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk    (clk),
      .we     (wr_ok),
      .w_addr (w_ptr[AW-1:0]),
      .w_data (data_in),
      .r_addr (r_ptr[AW-1:0]),
      .r_data (mem_rdata)
   );

   if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = mem_rdata;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= mem_rdata;
         end
      end

      assign data_out = dout_q;
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one registered-read and one FWFT instance share
// stimulus and are checked against a queue-based model plus directed vectors.
module tb_sync_fifo_flags;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout_0, dout_1;
   logic          full_0, empty_0, af_0, ae_0, ovf_0, unf_0;
   logic          full_1, empty_1, af_1, ae_1, ovf_1, unf_1;
   logic [CW-1:0] count_0, count_1;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   logic [DW-1:0] mdl_q[$];
   logic          mdl_ovf = 1'b0;
   logic          mdl_unf = 1'b0;
   logic [DW-1:0] mdl_dreg = '0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut_reg (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(dout_0),
      .full(full_0), .empty(empty_0), .almost_full(af_0), .almost_empty(ae_0), .count(count_0),
      .overflow(ovf_0), .underflow(unf_0), .err_clr(err_clr));

   sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut_fwft (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(dout_1),
      .full(full_1), .empty(empty_1), .almost_full(af_1), .almost_empty(ae_1), .count(count_1),
      .overflow(ovf_1), .underflow(unf_1), .err_clr(err_clr));

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      logic rd_ok, wr_ok;
      if (rst) begin
         mdl_q.delete();
         mdl_ovf  = 1'b0;
         mdl_unf  = 1'b0;
         mdl_dreg = '0;
      end else begin
         rd_ok = r_en && (mdl_q.size() > 0);
         wr_ok = w_en && ((mdl_q.size() < DEPTH) || rd_ok);
         if (rd_ok) mdl_dreg = mdl_q.pop_front();
         if (wr_ok) mdl_q.push_back(data_in);
         mdl_ovf = (w_en && !wr_ok) || (mdl_ovf && !err_clr);
         mdl_unf = (r_en && !rd_ok) || (mdl_unf && !err_clr);
      end
   endtask

   task automatic model_check();
      int n;
      n = mdl_q.size();
      chk("count_reg",  int'(count_0), n);
      chk("full_reg",   int'(full_0),  int'(n == DEPTH));
      chk("empty_reg",  int'(empty_0), int'(n == 0));
      chk("af_reg",     int'(af_0),    int'(n >= AF));
      chk("ae_reg",     int'(ae_0),    int'(n <= AE));
      chk("ovf_reg",    int'(ovf_0),   int'(mdl_ovf));
      chk("unf_reg",    int'(unf_0),   int'(mdl_unf));
      chk("dout_reg",   int'(dout_0),  int'(mdl_dreg));
      chk("count_fwft", int'(count_1), n);
      chk("empty_fwft", int'(empty_1), int'(n == 0));
      chk("ovf_fwft",   int'(ovf_1),   int'(mdl_ovf));
      chk("unf_fwft",   int'(unf_1),   int'(mdl_unf));
      if (n > 0) chk("dout_fwft", int'(dout_1), int'(mdl_q[0]));
   endtask

   // Drive one cycle of inputs, update the model at the edge, check 1 time unit later.
   task automatic step(input logic s_rst, input logic s_w, input logic [DW-1:0] s_d,
                       input logic s_r, input logic s_clr);
      @(negedge clk);
      rst = s_rst; w_en = s_w; data_in = s_d; r_en = s_r; err_clr = s_clr;
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   typedef struct {
      logic          rst, w, r, clr;
      logic [DW-1:0] din;
      int            cnt;
      logic          emp, ful, ovf, unf;
      logic [DW-1:0] d0;
      logic          fw_chk;
      logic [DW-1:0] d1;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{rst:1, w:0, r:0, clr:0, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:0, d0:8'h00, fw_chk:0, d1:8'h00};
      tbl[1] = '{rst:0, w:0, r:1, clr:0, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:1, d0:8'h00, fw_chk:0, d1:8'h00};
      tbl[2] = '{rst:0, w:1, r:1, clr:0, din:8'h55, cnt:1, emp:0, ful:0, ovf:0, unf:1, d0:8'h00, fw_chk:1, d1:8'h55};
      tbl[3] = '{rst:0, w:0, r:0, clr:1, din:8'h00, cnt:1, emp:0, ful:0, ovf:0, unf:0, d0:8'h00, fw_chk:1, d1:8'h55};
      tbl[4] = '{rst:0, w:1, r:0, clr:0, din:8'h11, cnt:2, emp:0, ful:0, ovf:0, unf:0, d0:8'h00, fw_chk:1, d1:8'h55};
      tbl[5] = '{rst:0, w:0, r:1, clr:0, din:8'h00, cnt:1, emp:0, ful:0, ovf:0, unf:0, d0:8'h55, fw_chk:1, d1:8'h11};
      tbl[6] = '{rst:0, w:0, r:1, clr:0, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:0, d0:8'h11, fw_chk:0, d1:8'h00};
      tbl[7] = '{rst:0, w:0, r:1, clr:1, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:1, d0:8'h11, fw_chk:0, d1:8'h00};

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].rst, tbl[i].w, tbl[i].din, tbl[i].r, tbl[i].clr);
         chk($sformatf("tbl%0d_count", i), int'(count_0), tbl[i].cnt);
         chk($sformatf("tbl%0d_empty", i), int'(empty_0), int'(tbl[i].emp));
         chk($sformatf("tbl%0d_full", i),  int'(full_0),  int'(tbl[i].ful));
         chk($sformatf("tbl%0d_ovf", i),   int'(ovf_0),   int'(tbl[i].ovf));
         chk($sformatf("tbl%0d_unf", i),   int'(unf_0),   int'(tbl[i].unf));
         chk($sformatf("tbl%0d_dout", i),  int'(dout_0),  int'(tbl[i].d0));
         if (tbl[i].fw_chk) chk($sformatf("tbl%0d_dout_fwft", i), int'(dout_1), int'(tbl[i].d1));
      end

      // fill 16 words, then drain in order
      step(1, 0, 8'h00, 0, 0);
      chk("rst_ae", int'(ae_0), 1);
      chk("rst_af", int'(af_0), 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, DW'(i), 0, 0);
         chk("fill_af", int'(af_0), int'((i + 1) >= 14));
         chk("fill_full", int'(full_0), int'(i == DEPTH - 1));
      end
      chk("fill_count16", int'(count_0), 16);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 8'h00, 1, 0);
         chk("drain_data", int'(dout_0), i);
      end
      chk("drain_empty", int'(empty_0), 1);

      // refill, then a rejected write sets overflow
      for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i), 0, 0);
      step(0, 1, 8'hAA, 0, 0);
      chk("ovf_set", int'(ovf_0), 1);
      chk("ovf_count", int'(count_0), 16);
      step(0, 0, 8'h00, 0, 1);
      chk("ovf_clr", int'(ovf_0), 0);

      // simultaneous write+read while full, across pointer wrap
      for (int k = 0; k < 20; k++) begin
         step(0, 1, DW'(8'h80 + k), 1, 0);
         chk("wr_rd_count", int'(count_0), 16);
         chk("wr_rd_ovf", int'(ovf_0), 0);
         chk("wr_rd_data", int'(dout_0), (k < 16) ? k : (8'h80 + k - 16));
      end

      // underflow keeps data_out, then write+read into empty
      step(1, 0, 8'h00, 0, 0);
      step(0, 1, 8'h77, 0, 0);
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("unf_set", int'(unf_0), 1);
      chk("unf_dout_hold", int'(dout_0), 8'h77);
      step(0, 1, 8'h55, 1, 0);
      chk("unf_wr_count", int'(count_0), 1);
      chk("unf_sticky", int'(unf_0), 1);

      // FWFT: word appears the cycle after its write
      step(1, 0, 8'h00, 0, 0);
      step(0, 1, 8'h3C, 0, 0);
      chk("fwft_dout", int'(dout_1), 8'h3C);
      chk("fwft_not_empty", int'(empty_1), 0);
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_hold", int'(dout_1), 8'h3C);
      step(0, 0, 8'h00, 1, 0);
      chk("fwft_pop_empty", int'(empty_1), 1);

      // reset mid-burst discards the write in the reset cycle
      for (int i = 0; i < 9; i++) step(0, 1, DW'(8'h20 + i), 0, 0);
      chk("pre_rst_count", int'(count_0), 9);
      step(1, 1, 8'hEE, 0, 0);
      chk("rst_count", int'(count_0), 0);
      chk("rst_empty", int'(empty_0), 1);
      step(0, 0, 8'h00, 0, 0);
      chk("rst_discard", int'(count_0), 0);

      // randomized traffic with varying read/write bias
      for (int i = 0; i < 3000; i++) begin
         int wp, rp;
         wp = ((i / 500) % 2 == 0) ? 70 : 35;
         rp = 100 - wp;
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < wp), DW'($urandom),
              ($urandom_range(0, 99) < rp), ($urandom_range(0, 19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parameterised single-clock FIFO that supersedes the basic synchronous FIFO.
- All DEPTH entries are usable, via pointers carrying an extra wrap bit.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer datapath stages inside one clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of 2 and >= 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (in FWFT mode: pop/acknowledge of the head word).
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst high at posedge): w_ptr = 0, r_ptr = 0, count = 0, overflow = 0, underflow = 0.
  - FWFT=0: registered data_out = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - Memory contents are not reset.
  - Reset takes priority over every other input, including mid-burst.
- Pointers are $clog2(DEPTH)+1 bits; low bits index memory and wrap naturally at DEPTH.
  - empty: pointers equal.
  - full: MSBs differ, low bits equal.
- Read accepted (rd_ok) = r_en && !empty.
- Write accepted (wr_ok) = w_en && (!full || rd_ok).
  - A write while full is accepted only when a read is accepted in the same cycle.
  - The write lands in the slot being vacated; the read returns the old word.
- Write while empty with r_en also high: the write is accepted and the read is rejected (underflow set). The new word is visible on the next cycle.
- count next-state:
  - +1 when wr_ok && !rd_ok.
  - -1 when rd_ok && !wr_ok.
  - Unchanged otherwise.
  - All flags are derived combinationally from registered count/pointers, so they are valid the cycle after the update.
- FWFT=0: on rd_ok, data_out <= mem[r_ptr] at that edge (1-cycle latency). data_out holds its value when no read is accepted.
- FWFT=1: data_out = mem[r_ptr] combinationally whenever !empty; r_en pops. data_out is don't-care while empty.
  - A word written into an empty FIFO appears on data_out one cycle after its write edge.
- Error flags:
  - overflow sets on w_en && !wr_ok.
  - underflow sets on r_en && !rd_ok.
  - Both clear on err_clr.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - Rejected operations do not change pointers, count or memory.
- Parameter checks: elaboration fails if DEPTH is not a power of 2, if AF_LEVEL > DEPTH, or if AE_LEVEL >= DEPTH.

Decomposition:
- Package sync_fifo_pkg: function ptr_w(DEPTH) = $clog2(DEPTH)+1, and localparams FWFT_OFF = 0 and FWFT_ON = 1.
- One sub-module, sync_fifo_mem: simple dual-port array with a synchronous write port and an asynchronous read port, parameterised on DATA_WIDTH/DEPTH. The top holds pointers, count, flags and the output register.

Test Plan:
- DEPTH=16, FWFT=0: write 16 words 0x00..0x0F.
  - full rises after the 16th edge, count = 16, almost_full from count = 14.
  - Read 16: data_out = 0x00..0x0F, each one cycle after r_en; empty after the last read.
- Full, then w_en alone with data_in = 0xAA: overflow = 1, count stays 16, 0xAA is never read back.
  - err_clr then drops overflow.
- Full, then w_en + r_en together for 20 cycles: count stays 16, no overflow, read order is preserved across pointer wrap.
- Empty, then r_en alone: underflow = 1, data_out unchanged.
  - Then w_en + r_en with 0x55: write accepted, underflow stays 1, count = 1.
- FWFT=1: write 0x3C into empty FIFO → data_out = 0x3C, empty = 0 next cycle with no r_en.
  - Pop → empty = 1 next cycle.
- Fill to 9, assert rst for one cycle while w_en = 1: next cycle count = 0, empty = 1, flags clear, the write in the reset cycle is discarded.
